// File: rtl/fmap_comp_pkg.sv
// fmap_comp_pkg: default grid geometry, derived constants, position bundle
// and the tile-origin helper shared by the compositor and its decoder.
package fmap_comp_pkg;

    localparam int DEF_X_SIZE     = 640;
    localparam int DEF_Y_SIZE     = 480;
    localparam int DEF_READ_WIDTH = 256;
    localparam int DEF_PIX_BITS   = 8;
    localparam int DEF_N_TILES    = 4;
    localparam int DEF_GRID_COLS  = 2;
    localparam int DEF_TILE_W     = 24;
    localparam int DEF_TILE_H     = 24;
    localparam int DEF_SCALE_LOG2 = 2;
    localparam int DEF_GAP        = 8;
    localparam int DEF_ORIGIN_X   = 0;
    localparam int DEF_ORIGIN_Y   = 0;
    localparam int DEF_BASE_ADDR  = 0;
    localparam logic [7:0] DEF_BG_VAL = 8'h00;

    localparam int PIX_PER_WORD   = DEF_READ_WIDTH / DEF_PIX_BITS;
    localparam int WORDS_PER_TILE =
        (DEF_TILE_W * DEF_TILE_H + PIX_PER_WORD - 1) / PIX_PER_WORD;
    localparam int X_W    = $clog2(DEF_X_SIZE);
    localparam int Y_W    = $clog2(DEF_Y_SIZE);
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           first;
        logic           lastx;
        logic           lasty;
    } pixel_pos_t;

    typedef struct packed {
        int ox;
        int oy;
    } tile_org_t;

    // Top-left corner of tile t on the screen grid.
    function automatic tile_org_t tile_origin(
        input int t,
        input int cols,
        input int pitch_x,
        input int pitch_y,
        input int x0,
        input int y0
    );
        tile_org_t o;
        o.ox = x0 + (t % cols) * pitch_x;
        o.oy = y0 + (t / cols) * pitch_y;
        return o;
    endfunction

    function automatic int words_per_tile(
        input int w,
        input int h,
        input int ppw
    );
        return (w * h + ppw - 1) / ppw;
    endfunction

endpackage

// File: rtl/fmap_tile_decode.sv
// fmap_tile_decode: combinational (x,y) -> hit, BRAM word address, lane.
// Ports: x,y in; hit, addr, lane out; border out with FMAP_TILE_BORDER_EN.
module fmap_tile_decode
    import fmap_comp_pkg::*;
#(
    parameter int N_TILES    = DEF_N_TILES,
    parameter int GRID_COLS  = DEF_GRID_COLS,
    parameter int TILE_W     = DEF_TILE_W,
    parameter int TILE_H     = DEF_TILE_H,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int GAP        = DEF_GAP,
    parameter int ORIGIN_X   = DEF_ORIGIN_X,
    parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int PPW        = PIX_PER_WORD,
    parameter int LANE_W     = $clog2(PPW)
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic              hit,
    output logic [ADDR_W-1:0] addr,
    output logic [LANE_W-1:0] lane
`ifdef FMAP_TILE_BORDER_EN
    ,
    output logic              border
`endif
);

    localparam int SW  = TILE_W << SCALE_LOG2;
    localparam int SH  = TILE_H << SCALE_LOG2;
    localparam int WPT = words_per_tile(TILE_W, TILE_H, PPW);

    tile_org_t org;
    int        dx;
    int        dy;
    int        idx;

    always_comb begin
        hit  = 1'b0;
        addr = '0;
        lane = '0;
`ifdef FMAP_TILE_BORDER_EN
        border = 1'b0;
`endif
        org = '0;
        dx  = 0;
        dy  = 0;
        idx = 0;
        for (int t = 0; t < N_TILES; t++) begin
            org = tile_origin(t, GRID_COLS, SW + GAP, SH + GAP,
                              ORIGIN_X, ORIGIN_Y);
            dx = int'(x) - org.ox;
            dy = int'(y) - org.oy;
            // First match wins, so lower tile indices take priority.
            if (!hit && dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
                hit  = 1'b1;
                idx  = (dy >> SCALE_LOG2) * TILE_W + (dx >> SCALE_LOG2);
                addr = ADDR_W'(BASE_ADDR + t * WPT + (idx >> LANE_W));
                lane = LANE_W'(idx & (PPW - 1));
`ifdef FMAP_TILE_BORDER_EN
                border = (dx == 0) || (dx == SW - 1) ||
                         (dy == 0) || (dy == SH - 1);
`endif
            end
        end
    end

endmodule

// File: rtl/fmap_grid_compositor.sv
// fmap_grid_compositor: streams an X_SIZE x Y_SIZE frame, placing upscaled
// feature-map tiles from BRAM on a grid; 3-stage stall-all pipeline.
// Ports: out_stream_aclk, periph_reset (sync, high), enable, out_ready in;
// out_valid/pixel/first/lastx/lasty, frame_done out; bram_addr/en out,
// bram_rdata in. Optional tile outline: FMAP_TILE_BORDER_EN.
module fmap_grid_compositor
    import fmap_comp_pkg::*;
#(
    parameter int X_SIZE     = DEF_X_SIZE,
    parameter int Y_SIZE     = DEF_Y_SIZE,
    parameter int READ_WIDTH = DEF_READ_WIDTH,
    parameter int PIX_BITS   = DEF_PIX_BITS,
    parameter int N_TILES    = DEF_N_TILES,
    parameter int GRID_COLS  = DEF_GRID_COLS,
    parameter int TILE_W     = DEF_TILE_W,
    parameter int TILE_H     = DEF_TILE_H,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int GAP        = DEF_GAP,
    parameter int ORIGIN_X   = DEF_ORIGIN_X,
    parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter logic [PIX_BITS-1:0] BG_VAL = PIX_BITS'(DEF_BG_VAL)
) (
    input  logic                  out_stream_aclk,
    input  logic                  periph_reset,
    input  logic                  enable,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [PIX_BITS-1:0]   out_pixel,
    output logic                  out_first,
    output logic                  out_lastx,
    output logic                  out_lasty,
    output logic                  frame_done,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic                  bram_en,
    input  logic [READ_WIDTH-1:0] bram_rdata
);

    localparam int PPW    = READ_WIDTH / PIX_BITS;
    localparam int LANE_W = $clog2(PPW);
    localparam int WPT    = words_per_tile(TILE_W, TILE_H, PPW);

    if (BASE_ADDR + N_TILES * WPT > 4096) begin : g_chk_addr
        $error("tile storage exceeds the 4096-word BRAM");
    end
    if (X_SIZE > (1 << X_W) || Y_SIZE > (1 << Y_W)) begin : g_chk_pos
        $error("frame size exceeds position counter width");
    end

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    pixel_pos_t        s0_pos;
    logic              s0_valid;
    logic              at_origin;
    logic              advance;
    logic              dec_hit;
    logic [ADDR_W-1:0] dec_addr;
    logic [LANE_W-1:0] dec_lane;
    logic              s1_valid;
    logic              s1_hit;
    logic              s1_first;
    logic              s1_lastx;
    logic              s1_lasty;
    logic [LANE_W-1:0] s1_lane;
    logic              s2_valid;
    logic              s2_hit;
    logic [LANE_W-1:0] s2_lane;
    logic [PIX_BITS-1:0] lane_pix;
`ifdef FMAP_TILE_BORDER_EN
    logic              dec_border;
    logic              s1_border;
    logic              s2_border;
`endif

    assign at_origin = (x == '0) && (y == '0);
    // enable only gates the start of a frame; mid-frame it is ignored.
    assign s0_valid  = at_origin ? enable : 1'b1;
    assign advance   = !s2_valid || out_ready;
    // Holding bram_en low during a stall freezes the BRAM output word.
    assign bram_en   = advance && !periph_reset;

    always_comb begin
        s0_pos.x     = x;
        s0_pos.y     = y;
        s0_pos.first = s0_valid && at_origin;
        s0_pos.lastx = s0_valid && (x == X_W'(X_SIZE - 1));
        s0_pos.lasty = s0_valid && (y == Y_W'(Y_SIZE - 1));
    end

    fmap_tile_decode #(
        .N_TILES    (N_TILES),
        .GRID_COLS  (GRID_COLS),
        .TILE_W     (TILE_W),
        .TILE_H     (TILE_H),
        .SCALE_LOG2 (SCALE_LOG2),
        .GAP        (GAP),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .BASE_ADDR  (BASE_ADDR),
        .PPW        (PPW),
        .LANE_W     (LANE_W)
    ) u_decode (
        .x      (s0_pos.x),
        .y      (s0_pos.y),
        .hit    (dec_hit),
        .addr   (dec_addr),
        .lane   (dec_lane)
`ifdef FMAP_TILE_BORDER_EN
        ,
        .border (dec_border)
`endif
    );

    // S0: raster position counter.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            x <= '0;
            y <= '0;
        end else if (advance && s0_valid) begin
            if (s0_pos.lastx) begin
                x <= '0;
                y <= s0_pos.lasty ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // S1: registered decode; bram_addr only moves on a tile hit.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            s1_valid  <= 1'b0;
            s1_hit    <= 1'b0;
            s1_lane   <= '0;
            s1_first  <= 1'b0;
            s1_lastx  <= 1'b0;
            s1_lasty  <= 1'b0;
            bram_addr <= '0;
`ifdef FMAP_TILE_BORDER_EN
            s1_border <= 1'b0;
`endif
        end else if (advance) begin
            s1_valid <= s0_valid;
            s1_hit   <= s0_valid && dec_hit;
            s1_lane  <= dec_lane;
            s1_first <= s0_pos.first;
            s1_lastx <= s0_pos.lastx;
            s1_lasty <= s0_pos.lasty;
            if (s0_valid && dec_hit)
                bram_addr <= dec_addr;
`ifdef FMAP_TILE_BORDER_EN
            s1_border <= dec_border;
`endif
        end
    end

    // S2: sideband aligned with the BRAM read data.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            s2_valid  <= 1'b0;
            s2_hit    <= 1'b0;
            s2_lane   <= '0;
            out_first <= 1'b0;
            out_lastx <= 1'b0;
            out_lasty <= 1'b0;
`ifdef FMAP_TILE_BORDER_EN
            s2_border <= 1'b0;
`endif
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_hit    <= s1_hit;
            s2_lane   <= s1_lane;
            out_first <= s1_first;
            out_lastx <= s1_lastx;
            out_lasty <= s1_lasty;
`ifdef FMAP_TILE_BORDER_EN
            s2_border <= s1_border;
`endif
        end
    end

    always_comb begin
        lane_pix = '0;
        for (int l = 0; l < PPW; l++) begin
            if (s2_lane == LANE_W'(l))
                lane_pix = bram_rdata[l*PIX_BITS +: PIX_BITS];
        end
    end

    always_comb begin
        out_pixel = BG_VAL;
        if (s2_hit)
            out_pixel = lane_pix;
`ifdef FMAP_TILE_BORDER_EN
        if (s2_hit && s2_border)
            out_pixel = '1;
`endif
    end

    assign out_valid  = s2_valid;
    assign frame_done = out_valid && out_ready && out_lastx && out_lasty;

endmodule

// File: tb/tb_fmap_grid_compositor.sv
// tb_fmap_grid_compositor: directed bench for the grid compositor on a
// reduced 200x112 frame with default tile geometry and a BRAM model.
module tb_fmap_grid_compositor;

    localparam int XS = 200;
    localparam int YS = 112;
`ifdef FMAP_TILE_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    logic         clk;
    logic         periph_reset;
    logic         enable;
    logic         out_ready;
    logic         out_valid;
    logic [7:0]   out_pixel;
    logic         out_first;
    logic         out_lastx;
    logic         out_lasty;
    logic         frame_done;
    logic [11:0]  bram_addr;
    logic         bram_en;
    logic [255:0] bram_rdata;

    fmap_grid_compositor #(
        .X_SIZE (XS),
        .Y_SIZE (YS)
    ) dut (
        .out_stream_aclk (clk),
        .periph_reset    (periph_reset),
        .enable          (enable),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_pixel       (out_pixel),
        .out_first       (out_first),
        .out_lastx       (out_lastx),
        .out_lasty       (out_lasty),
        .frame_done      (frame_done),
        .bram_addr       (bram_addr),
        .bram_en         (bram_en),
        .bram_rdata      (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int a, input int l);
        return 8'(((a * 41) + (l * 3)) ^ 8'hC3);
    endfunction

    function automatic logic [255:0] word(input int a);
        logic [255:0] w;
        for (int l = 0; l < 32; l++) w[l*8 +: 8] = pix(a, l);
        return w;
    endfunction

    initial bram_rdata = '0;
    always @(posedge clk)
        if (bram_en) bram_rdata <= word(int'(bram_addr));

    // Reference: tiles 96 px wide on a 104 px pitch, 2x2 grid.
    function automatic logic [7:0] model(input int x, input int y);
        int col, row, dx, dy, idx;
        col = x / 104;
        row = y / 104;
        dx  = x % 104;
        dy  = y % 104;
        if (col > 1 || row > 1 || dx >= 96 || dy >= 96) return 8'h00;
        if (BORDER_EN && (dx == 0 || dx == 95 || dy == 0 || dy == 95))
            return 8'hFF;
        idx = (dy / 4) * 24 + dx / 4;
        return pix((row * 2 + col) * 18 + idx / 32, idx % 32);
    endfunction

    // Scoreboard: tracks accepted pixel positions.
    int   ex = 0, ey = 0, sb_err = 0, sb_n = 0, done_cnt = 0;
    int   err_x = 0, err_y = 0;
    bit   sb_on = 0, cap_on = 0;
    logic [7:0] cap [XS*YS];

    always @(negedge clk) begin : mon
        bit acc, ok;
        if (sb_on) begin
            acc = out_valid && out_ready;
            ok  = (frame_done === (acc && ex == XS-1 && ey == YS-1));
            if (frame_done) done_cnt++;
            if (acc) begin
                ok = ok && (out_first === (ex == 0 && ey == 0));
                ok = ok && (out_lastx === (ex == XS-1));
                ok = ok && (out_lasty === (ey == YS-1));
                ok = ok && (out_pixel === model(ex, ey));
                if (cap_on) cap[ey*XS + ex] = out_pixel;
                sb_n++;
            end
            if (!ok) begin
                if (sb_err == 0) begin
                    err_x = ex;
                    err_y = ey;
                end
                sb_err++;
            end
            if (acc) begin
                if (ex == XS-1) begin
                    ex = 0;
                    ey = (ey == YS-1) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
        end
    end

    typedef struct {
        int x;
        int y;
        bit hit;
        int addr;
        int lane;
        bit brd;
    } vec_t;

    vec_t vt[19];

    initial begin : main
        bit got;
        logic [7:0] e;
        vt[0]  = '{0,   0,   1, 0,  0,  1};
        vt[1]  = '{3,   3,   1, 0,  0,  0};
        vt[2]  = '{4,   0,   1, 0,  1,  1};
        vt[3]  = '{0,   4,   1, 0,  24, 1};
        vt[4]  = '{5,   5,   1, 0,  25, 0};
        vt[5]  = '{0,   8,   1, 1,  16, 1};
        vt[6]  = '{95,  95,  1, 17, 31, 1};
        vt[7]  = '{104, 0,   1, 18, 0,  1};
        vt[8]  = '{100, 0,   0, 0,  0,  0};
        vt[9]  = '{0,   104, 1, 36, 0,  1};
        vt[10] = '{1,   1,   1, 0,  0,  0};
        vt[11] = '{95,  10,  1, 2,  7,  1};
        vt[12] = '{104, 95,  1, 35, 8,  1};
        vt[13] = '{199, 50,  1, 27, 23, 1};
        vt[14] = '{150, 104, 1, 54, 11, 1};
        vt[15] = '{50,  60,  1, 11, 20, 0};
        vt[16] = '{96,  50,  0, 0,  0,  0};
        vt[17] = '{50,  100, 0, 0,  0,  0};
        vt[18] = '{120, 111, 1, 54, 28, 0};

        periph_reset = 1'b1;
        enable       = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        periph_reset = 1'b0;
        enable       = 1'b1;
        repeat (300) @(posedge clk);
        #1;

        // Reset in the middle of a frame.
        periph_reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_bram_en", bram_en, 0);
            chk("rst_bram_addr", bram_addr, 0);
        end
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_first", out_first, 0);
        periph_reset = 1'b0;
        sb_on  = 1;
        cap_on = 1;

        // First pixel after reset is (0,0) flagged first.
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) got = 1;
        end
        if (!got) chk("first_wait_timeout", 0, 1);
        chk("first_after_rst", out_first, 1);
        chk("first_after_rst_pix", out_pixel, model(0, 0));

        // Backpressure while (5,0) is on the output.
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (out_valid && ex == 5 && ey == 0) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) chk("stall_wait_timeout", 0, 1);
        out_ready = 1'b0;
        e = BORDER_EN ? 8'hFF : pix(0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_pixel", out_pixel, e);
            chk("stall_flags", {out_first, out_lastx, out_lasty}, 0);
            chk("stall_bram_addr", bram_addr, 0);
            chk("stall_bram_en", bram_en, 0);
            chk("stall_x", dut.x, 7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // End of frame A with enable held high.
        got = 0;
        for (int i = 0; i < 30000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt >= 1) got = 1;
        end
        if (!got) chk("frameA_timeout", 0, 1);
        cap_on = 0;
        chk("frameA_done_cnt", done_cnt, 1);
        chk("frameB_first_valid", out_valid, 1);
        chk("frameB_first_flag", out_first, 1);
        chk("frameA_pixels", sb_n, XS*YS);
        chk("frameA_sb_errs", sb_err, 0);
        if (sb_err != 0) $display("first bad pixel x=%0d y=%0d", err_x, err_y);
        sb_n   = 0;
        enable = 1'b0;

        for (int i = 0; i < 19; i++) begin
            if (!vt[i].hit) e = 8'h00;
            else if (BORDER_EN && vt[i].brd) e = 8'hFF;
            else e = pix(vt[i].addr, vt[i].lane);
            chk($sformatf("vec_%0d_%0d", vt[i].x, vt[i].y),
                cap[vt[i].y*XS + vt[i].x], e);
        end

        // Frame B under periodic backpressure, enable already dropped.
        got = 0;
        for (int i = 0; i < 40000 && !got; i++) begin
            @(posedge clk);
            #1;
            out_ready = (i % 5) != 3;
            if (done_cnt >= 2) got = 1;
        end
        if (!got) chk("frameB_timeout", 0, 1);
        out_ready = 1'b1;
        chk("frameB_done_cnt", done_cnt, 2);
        chk("frameB_pixels", sb_n, XS*YS);
        chk("frameB_sb_errs", sb_err, 0);

        repeat (2) @(negedge clk);
        chk("drain_valid", out_valid, 0);
        sb_n = 0;
        repeat (20) @(negedge clk);
        chk("idle_pixels", sb_n, 0);
        chk("idle_done_cnt", done_cnt, 2);
        chk("idle_x", dut.x, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmap_grid_compositor.md
Name: fmap_grid_compositor

Overview:
Parametrised successor to the single-pair feature-map tiler. It streams a full X_SIZE×Y_SIZE monitor frame and places N_TILES feature maps on a regular grid, each upscaled by 2^SCALE_LOG2. Every output pixel's BRAM word and lane are computed directly from (x,y), with no per-tile reader state, and the block absorbs the 1-cycle BRAM read latency in a stall-all pipeline. It sits between the feature-map BRAM read port and the AXI-stream video output.

Parameters:
X_SIZE, 640, active pixels per line
Y_SIZE, 480, active lines per frame
READ_WIDTH, 256, BRAM word width in bits
PIX_BITS, 8, bits per pixel; PIX_PER_WORD = READ_WIDTH/PIX_BITS, must be a power of two
N_TILES, 4, number of feature maps, 1..16
GRID_COLS, 2, tiles per grid row
TILE_W, 24, feature-map width in source pixels
TILE_H, 24, feature-map height in source pixels
SCALE_LOG2, 2, upscale shift; the scaled tile is TILE_W<<SCALE_LOG2 wide
GAP, 8, background pixels between scaled tiles, both axes
ORIGIN_X, 0, x of the tile-0 top-left corner
ORIGIN_Y, 0, y of the tile-0 top-left corner
BASE_ADDR, 0, BRAM word address of tile 0; tile t base = BASE_ADDR + t*WORDS_PER_TILE, where WORDS_PER_TILE = ceil(TILE_W*TILE_H/PIX_PER_WORD)
BG_VAL, 8'h00, background pixel value

Ports:
out_stream_aclk  in  1  sole clock
periph_reset  in  1  synchronous, active-high reset
enable  in  1  permits a frame to start
out_ready  in  1  downstream ready
out_valid  out  1  pixel valid
out_pixel  out  PIX_BITS  pixel data
out_first  out  1  pixel (0,0), used as tuser
out_lastx  out  1  x = X_SIZE-1, used as tlast
out_lasty  out  1  y = Y_SIZE-1
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
bram_addr  out  12  BRAM read address
bram_en  out  1  BRAM read enable
bram_rdata  in  READ_WIDTH  BRAM data, valid 1 cycle after address with bram_en=1

Behaviour:
- Reset is synchronous on periph_reset=1. All valid flags clear, x=y=0, bram_addr=0, bram_en=0, out_* = 0, frame_done=0. Reset asserted mid-frame discards all in-flight pixels.
- Pipeline: S0 position counter, S1 registered decode (drives bram_addr), S2 registered sideband. advance = !s2_valid || out_ready. All stages move only when advance=1, and bram_en = advance, so BRAM output holds during a stall.
- out_valid = s2_valid. out_pixel = BG_VAL if S2 is outside all tiles, else the lane s2_lane of bram_rdata (lane 0 = bits [PIX_BITS-1:0]).
- Latency: a pixel generated in S0 at cycle n appears on the output at cycle n+2 with no stall.
- S0 frame control: counter is IDLE until enable=1 at (0,0). It then raster-scans, x fastest, one position per advance. At x=X_SIZE-1, x wraps to 0 and y increments. At (X_SIZE-1,Y_SIZE-1) the counter wraps to (0,0).
- enable is sampled only at (0,0). Deasserting it mid-frame has no effect until frame end; the pipeline then drains and out_valid falls.
- Tile t geometry: col = t%GRID_COLS, row = t/GRID_COLS. ox = ORIGIN_X + col*((TILE_W<<SCALE_LOG2)+GAP). oy = ORIGIN_Y + row*((TILE_H<<SCALE_LOG2)+GAP).
- Hit test: ox ≤ x < ox+(TILE_W<<SCALE_LOG2) and oy ≤ y < oy+(TILE_H<<SCALE_LOG2). Tiles lying beyond the screen are never hit. The lowest index wins; the grid cannot overlap by construction.
- Address: sx = (x-ox)>>SCALE_LOG2, sy = (y-oy)>>SCALE_LOG2, idx = sy*TILE_W + sx. bram_addr = tile base + idx/PIX_PER_WORD; lane = idx%PIX_PER_WORD, via shift/mask only.
- TILE_W multiply is by a constant. Intermediate widths hold at least clog2(TILE_W*TILE_H).
- Outside all tiles: bram_addr holds its previous value, and bram_en still follows advance.
- Flags out_first/out_lastx/out_lasty are computed at S0 and travel with the pixel.
- frame_done = out_valid & out_ready & out_lastx & out_lasty.
- Elaboration assertion: the last tile's base + WORDS_PER_TILE must be ≤ 4096.

Optional Feature:
FMAP_TILE_BORDER_EN
- Defined: scaled-tile pixels with x-ox ∈ {0, (TILE_W<<SCALE_LOG2)-1} or y-oy ∈ {0, (TILE_H<<SCALE_LOG2)-1} output {PIX_BITS{1'b1}} instead of BRAM data. Addressing is unchanged.
- Undefined: no border; the hardware is absent.

Decomposition:
- Package fmap_comp_pkg holds: the tile geometry function tile_origin(t) returning (ox,oy), the WORDS_PER_TILE and PIX_PER_WORD constants, the X_W=$clog2(X_SIZE) and Y_W widths, and a pixel_pos_t struct {x,y,first,lastx,lasty}.
- Sub-module fmap_tile_decode: purely combinational (x,y) → {hit, tile_idx, addr, lane, border}, instanced once in S0→S1.

Test Plan:
1. Reset: periph_reset high for 3 cycles mid-frame → out_valid=0, bram_en=0, bram_addr=0. After release, the first out_first pixel is (0,0).
2. Tile 0, defaults: (0..3,0..3) → addr 0, lane 0. (4,0) → lane 1. (0,4) → lane 24. (0,8) → addr 1, lane 16. (95,95) → addr 17, lane 31.
3. Tile 1 at ox=104: (104,0) → addr 18, lane 0. (100,0) → BG_VAL 8'h00. Tile 2: (0,104) → addr 36.
4. Backpressure: out_ready=0 for 5 cycles at x=5 → out_pixel, flags, bram_addr and x all stable. Resume → (6,0) follows with no duplicates or drops.
5. Frame end: (639,479) accepted → out_lastx=out_lasty=1 and frame_done pulses once. Next pixel is out_first if enable=1. If enable=0, out_valid falls after 2-cycle drain.
6. FMAP_TILE_BORDER_EN defined: (0,0), (95,10), (104,95) → 8'hFF; (1,1) → BRAM lane 0.
